bcd_time_register: RTL and testbench
====================================

Name: bcd_time_register

Overview:
- Parametrised two-digit BCD time register, successor to the fixed 00-59 minutes/seconds register.
- Counts between MIN_VALUE and MAX_VALUE, so one block covers seconds, minutes, 24 h hours and 12 h hours (01-12).
- Adds synchronous reset, parallel load with range checking, and optional down-counting.
- Chained via overflow: the next stage's en = overflow of this stage AND the global tick enable.

Parameters:
- MAX_VALUE, 59, upper bound (decimal, 1..99); wrap point when counting up.
- MIN_VALUE, 0, lower bound (decimal, 0..MAX_VALUE-1); reset value and wrap target.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- en  input  1  count enable; one step per clk edge while high.
- load_en  input  1  parallel load strobe.
- load_msd  input  4  BCD tens digit to load.
- load_lsd  input  4  BCD units digit to load.
- dir  input  1  0 = count up, 1 = count down (see Optional Feature).
- data_msd  output  4  registered BCD tens digit.
- data_lsd  output  4  registered BCD units digit.
- overflow  output  1  combinational carry/borrow: high in the cycle the register wraps.

Behaviour:
- Reset: when reset_n is low at a rising edge, the register loads MIN_VALUE (e.g. 0,0 or 0,1). Overflow is forced low while reset_n is low.
- Priority per edge is reset_n low, then load_en, then en, then hold.
- Load:
  - Takes effect at the next edge.
  - Valid when both digits are at most 9 and MIN_VALUE ≤ 10*msd+lsd ≤ MAX_VALUE; otherwise MIN_VALUE is loaded.
  - Overflow is suppressed while load_en is high.
- Count up (en=1, dir=0):
  - lsd increments.
  - lsd 9 goes to 0 and msd increments.
  - At value == MAX_VALUE, the next value is MIN_VALUE.
- Count down (en=1, dir=1):
  - lsd decrements.
  - lsd 0 goes to 9 and msd decrements.
  - At value == MIN_VALUE, the next value is MAX_VALUE.
- overflow = en & ~load_en & reset_n & (dir ? value==MIN_VALUE : value==MAX_VALUE). It is high only in the cycle before the wrap edge, with no register delay, so chained stages step on the same edge.
- Latency: outputs change one clk after en or load_en is sampled. Hold when en=0 means outputs are stable indefinitely.
- Held en: steps every edge. A full cycle takes (MAX_VALUE-MIN_VALUE+1) edges, with exactly one overflow cycle.
- Direction change mid-count: takes effect on the next enabled edge; no state is lost.
- Out-of-range state (only possible via X or SEU): the next enabled edge or any load returns the value to MIN_VALUE.
- Digit arithmetic is 4-bit BCD per digit with no binary intermediate register. Comparison against the bounds uses constants derived at elaboration: MAX_MSD = MAX_VALUE/10, MAX_LSD = MAX_VALUE%10, and likewise for MIN.

Optional Feature:
- Macro: BCD_TIME_REGISTER_DOWN_EN.
- Defined: dir is honoured as described, and the down-count and borrow logic is synthesised.
- Undefined:
  - dir is ignored and treated as 0; only up-count logic exists.
  - overflow = en & ~load_en & reset_n & (value==MAX_VALUE).
  - Port list is unchanged.

Decomposition:
- Shared include `bcd_defs.vh`:
  - BCD digit width constant (4).
  - `BCD_MAX_DIGIT` (9).
  - Function `bcd_valid(digit)`.
  - Function `bcd_pair_to_int(msd,lsd)` for range checks, reused by the hours/alarm blocks.
- One sub-module `bcd_digit`:
  - Single 0-9 decade with inc/dec, carry/borrow out and a wrap-value input.
  - Instantiated twice. The top level overrides the msd/lsd next-value on bound wrap.

Test Plan:
- Reset: reset_n=0 for 2 clk with en=1, using MIN_VALUE=1, MAX_VALUE=12 → outputs 0,1; overflow=0 throughout reset.
- Up count, default params: en=1 for 60 clk from 00 → sequence 00..59,00. overflow high exactly once, in the cycle at 59. Chained minutes instance reads 01 after 60 clk and 00 after 3600 clk.
- Load:
  - load 4,2 → 42, then count resumes at 43.
  - load 6,5 → 00 (out of range).
  - load 1,A → 00 (invalid BCD).
  - load_en with en=1 at 59 → loaded value wins; overflow=0.
- Hours, MIN=0 MAX=23: load 2,3 then one en → 00 with overflow pulse; load 0,9 then en → 10.
- Down count (macro defined): from 00, dir=1, en=1 → 59,58 with overflow at 00. From 10 → 09. 12 h from 01 → 12.
- Macro undefined: dir=1, en=1 from 05 → 06; overflow only at 59.

Source files
------------

// File: rtl/bcd_time_register_pkg.sv
// Shared BCD definitions: digit width, digit bound and range-check helpers.
package bcd_time_register_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

    typedef logic [BCD_W-1:0] bcd_t;

    // True when the digit is a legal decimal digit (0-9).
    function automatic logic bcd_valid(input bcd_t digit);
        return digit <= BCD_MAX_DIGIT;
    endfunction

    // Decimal value of a tens/units pair, wide enough for invalid digits (max 165).
    function automatic logic [7:0] bcd_pair_to_int(input bcd_t msd, input bcd_t lsd);
        return (8'(msd) * 8'd10) + 8'(lsd);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single 0-9 decade: next value and carry/borrow for one up or down step.
// wrap_value is the digit produced when the step rolls past 9 (up) or 0 (down).
module bcd_digit
    import bcd_time_register_pkg::*;
(
    input  logic [BCD_W-1:0] value,
    input  logic             step,
    input  logic             down,
    input  logic [BCD_W-1:0] wrap_value,
    output logic [BCD_W-1:0] next_c,
    output logic             carry_c
);

    // One decade step with carry out on 9->wrap (up) or borrow on 0->wrap (down).
    always_comb begin
        next_c  = value;
        carry_c = 1'b0;
        if (step) begin
            if (down) begin
                if (value == 4'd0) begin
                    next_c  = wrap_value;
                    carry_c = 1'b1;
                end else begin
                    next_c = value - 4'd1;
                end
            end else begin
                if (value >= BCD_MAX_DIGIT) begin
                    next_c  = wrap_value;
                    carry_c = 1'b1;
                end else begin
                    next_c = value + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_time_register.sv
// Two-digit BCD time register counting between MIN_VALUE and MAX_VALUE with
// parallel load and a combinational wrap (overflow) output for chaining.
// Down-counting is present only when BCD_TIME_REGISTER_DOWN_EN is defined.
module bcd_time_register
    import bcd_time_register_pkg::*;
#(
    parameter int unsigned MAX_VALUE = 59,
    parameter int unsigned MIN_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load_en,
    input  logic [BCD_W-1:0] load_msd,
    input  logic [BCD_W-1:0] load_lsd,
    input  logic             dir,
    output logic [BCD_W-1:0] data_msd,
    output logic [BCD_W-1:0] data_lsd,
    output logic             overflow
);

    localparam bcd_t MAX_MSD = 4'(MAX_VALUE / 10);
    localparam bcd_t MAX_LSD = 4'(MAX_VALUE % 10);
    localparam bcd_t MIN_MSD = 4'(MIN_VALUE / 10);
    localparam bcd_t MIN_LSD = 4'(MIN_VALUE % 10);
    localparam logic [8:0] MAX_V = 9'(MAX_VALUE);
    localparam logic [8:0] MIN_V = 9'(MIN_VALUE);

    // Legal digits and inside [MIN_VALUE, MAX_VALUE]; +1 keeps the lower test non-trivial at MIN 0.
    function automatic logic in_bounds(input bcd_t msd, input bcd_t lsd);
        logic [8:0] v;
        v = 9'(bcd_pair_to_int(msd, lsd));
        return bcd_valid(msd) && bcd_valid(lsd) && ((v + 9'd1) > MIN_V) && (v <= MAX_V);
    endfunction

    bcd_t msd_q, lsd_q;
    bcd_t next_msd_c, next_lsd_c;
    bcd_t lsd_step_c, msd_step_c;
    bcd_t wrap_digit_c;
    logic lsd_carry_c;
    logic msd_carry_unused;
    logic down_c;
    logic at_max_c, at_min_c, wrap_c;

`ifdef BCD_TIME_REGISTER_DOWN_EN
    assign down_c = dir;
`else
    logic dir_unused;
    assign dir_unused = dir;
    assign down_c     = 1'b0;
`endif

    assign at_max_c     = (msd_q == MAX_MSD) && (lsd_q == MAX_LSD);
    assign at_min_c     = (msd_q == MIN_MSD) && (lsd_q == MIN_LSD);
    assign wrap_c       = down_c ? at_min_c : at_max_c;
    assign wrap_digit_c = down_c ? BCD_MAX_DIGIT : 4'd0;

    // Carry/borrow out to the next stage, valid in the cycle before the wrap edge.
    assign overflow = en & ~load_en & reset_n & wrap_c;

    bcd_digit u_lsd (
        .value      (lsd_q),
        .step       (en),
        .down       (down_c),
        .wrap_value (wrap_digit_c),
        .next_c     (lsd_step_c),
        .carry_c    (lsd_carry_c)
    );

    bcd_digit u_msd (
        .value      (msd_q),
        .step       (lsd_carry_c),
        .down       (down_c),
        .wrap_value (wrap_digit_c),
        .next_c     (msd_step_c),
        .carry_c    (msd_carry_unused)
    );

    // Next value: load beats count; bound wrap and corrupt state override the decade chain.
    always_comb begin
        next_msd_c = msd_q;
        next_lsd_c = lsd_q;
        if (load_en) begin
            if (in_bounds(load_msd, load_lsd)) begin
                next_msd_c = load_msd;
                next_lsd_c = load_lsd;
            end else begin
                next_msd_c = MIN_MSD;
                next_lsd_c = MIN_LSD;
            end
        end else if (en) begin
            if (!in_bounds(msd_q, lsd_q)) begin
                next_msd_c = MIN_MSD;
                next_lsd_c = MIN_LSD;
            end else if (wrap_c) begin
                next_msd_c = down_c ? MAX_MSD : MIN_MSD;
                next_lsd_c = down_c ? MAX_LSD : MIN_LSD;
            end else begin
                next_msd_c = msd_step_c;
                next_lsd_c = lsd_step_c;
            end
        end
    end

    // Digit registers with synchronous reset to MIN_VALUE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            msd_q <= MIN_MSD;
            lsd_q <= MIN_LSD;
        end else begin
            msd_q <= next_msd_c;
            lsd_q <= next_lsd_c;
        end
    end

    assign data_msd = msd_q;
    assign data_lsd = lsd_q;

endmodule

// File: tb/tb_bcd_time_register.sv
// Self-checking bench for bcd_time_register: seconds (0-59), chained minutes,
// 24 h hours (0-23) and 12 h hours (1-12) instances.
module tb_bcd_time_register;

    logic       clk = 1'b0;
    logic       rst_n   [4];
    logic       en      [4];
    logic       load_en [4];
    logic       dir     [4];
    logic [3:0] lm      [4];
    logic [3:0] ll      [4];
    logic [3:0] dm      [4];
    logic [3:0] dl      [4];
    logic       ovf     [4];
    logic       min_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign min_en = ovf[0] & en[0];

    bcd_time_register #(.MAX_VALUE(59), .MIN_VALUE(0)) u_sec (
        .clk(clk), .reset_n(rst_n[0]), .en(en[0]), .load_en(load_en[0]),
        .load_msd(lm[0]), .load_lsd(ll[0]), .dir(dir[0]),
        .data_msd(dm[0]), .data_lsd(dl[0]), .overflow(ovf[0]));

    bcd_time_register #(.MAX_VALUE(59), .MIN_VALUE(0)) u_min (
        .clk(clk), .reset_n(rst_n[1]), .en(min_en), .load_en(load_en[1]),
        .load_msd(lm[1]), .load_lsd(ll[1]), .dir(dir[1]),
        .data_msd(dm[1]), .data_lsd(dl[1]), .overflow(ovf[1]));

    bcd_time_register #(.MAX_VALUE(23), .MIN_VALUE(0)) u_h24 (
        .clk(clk), .reset_n(rst_n[2]), .en(en[2]), .load_en(load_en[2]),
        .load_msd(lm[2]), .load_lsd(ll[2]), .dir(dir[2]),
        .data_msd(dm[2]), .data_lsd(dl[2]), .overflow(ovf[2]));

    bcd_time_register #(.MAX_VALUE(12), .MIN_VALUE(1)) u_h12 (
        .clk(clk), .reset_n(rst_n[3]), .en(en[3]), .load_en(load_en[3]),
        .load_msd(lm[3]), .load_lsd(ll[3]), .dir(dir[3]),
        .data_msd(dm[3]), .data_lsd(dl[3]), .overflow(ovf[3]));

    typedef struct {
        logic       le;
        logic [3:0] m;
        logic [3:0] l;
        logic       e;
        int         xovf;
        int         xm;
        int         xl;
        string      name;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle on instance k; overflow is checked before the edge, digits after.
    task automatic step(input int k, input logic le, input logic [3:0] m, input logic [3:0] l,
                        input logic e, input logic d, input string name,
                        input int xovf, input int xm, input int xl);
        load_en[k] = le;
        lm[k]      = m;
        ll[k]      = l;
        en[k]      = e;
        dir[k]     = d;
        #1;
        chk({name, " ovf"}, int'(ovf[k]), xovf);
        @(posedge clk);
        #1;
        chk({name, " msd"}, int'(dm[k]), xm);
        chk({name, " lsd"}, int'(dl[k]), xl);
        load_en[k] = 1'b0;
        en[k]      = 1'b0;
        dir[k]     = 1'b0;
    endtask

    initial begin
        int v, nv, ovc, xo;
        logic rn, le, e, d, dn;
        logic [3:0] m, l;

        tbl[0]  = '{1'b1, 4'd4, 4'd2,  1'b0, 0, 4, 2, "load 42"};
        tbl[1]  = '{1'b0, 4'd0, 4'd0,  1'b1, 0, 4, 3, "count 43"};
        tbl[2]  = '{1'b1, 4'd6, 4'd5,  1'b0, 0, 0, 0, "load 65 range"};
        tbl[3]  = '{1'b1, 4'd1, 4'd10, 1'b0, 0, 0, 0, "load 1A bcd"};
        tbl[4]  = '{1'b1, 4'd5, 4'd9,  1'b0, 0, 5, 9, "load 59"};
        tbl[5]  = '{1'b1, 4'd3, 4'd0,  1'b1, 0, 3, 0, "load beats en"};
        tbl[6]  = '{1'b1, 4'd5, 4'd9,  1'b0, 0, 5, 9, "reload 59"};
        tbl[7]  = '{1'b0, 4'd0, 4'd0,  1'b1, 1, 0, 0, "wrap 59"};
        tbl[8]  = '{1'b0, 4'd0, 4'd0,  1'b0, 0, 0, 0, "hold"};
        tbl[9]  = '{1'b1, 4'd0, 4'd9,  1'b0, 0, 0, 9, "load 09"};
        tbl[10] = '{1'b0, 4'd0, 4'd0,  1'b1, 0, 1, 0, "carry 10"};

        for (int k = 0; k < 4; k++) begin
            rst_n[k] = 1'b0; en[k] = 1'b0; load_en[k] = 1'b0;
            dir[k] = 1'b0; lm[k] = 4'd0; ll[k] = 4'd0;
        end
        en[3] = 1'b1;

        // Reset held two cycles with en high on the 12 h instance.
        #1;
        chk("h12 rst ovf c0", int'(ovf[3]), 0);
        @(posedge clk); #1;
        chk("h12 rst ovf c1", int'(ovf[3]), 0);
        @(posedge clk); #1;
        chk("h12 rst ovf c2", int'(ovf[3]), 0);
        chk("h12 rst msd", int'(dm[3]), 0);
        chk("h12 rst lsd", int'(dl[3]), 1);
        chk("sec rst msd", int'(dm[0]), 0);
        chk("sec rst lsd", int'(dl[0]), 0);
        chk("sec rst ovf", int'(ovf[0]), 0);
        for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;
        en[3] = 1'b0;

        for (int i = 0; i < 11; i++)
            step(0, tbl[i].le, tbl[i].m, tbl[i].l, tbl[i].e, 1'b0, tbl[i].name,
                 tbl[i].xovf, tbl[i].xm, tbl[i].xl);

        // 24 h and 12 h bounds.
        step(2, 1'b1, 4'd2, 4'd3, 1'b0, 1'b0, "h24 load 23", 0, 2, 3);
        step(2, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "h24 wrap",    1, 0, 0);
        step(2, 1'b1, 4'd0, 4'd9, 1'b0, 1'b0, "h24 load 09", 0, 0, 9);
        step(2, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "h24 carry",   0, 1, 0);
        step(3, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0, "h12 load 12", 0, 1, 2);
        step(3, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "h12 wrap up", 1, 0, 1);
        step(3, 1'b1, 4'd1, 4'd3, 1'b0, 1'b0, "h12 load 13", 0, 0, 1);
        step(3, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "h12 load 00", 0, 0, 1);

`ifdef BCD_TIME_REGISTER_DOWN_EN
        step(3, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, "h12 down wrap", 1, 1, 2);
        step(0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, "down 10",       0, 0, 9);
        step(0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "load 00",       0, 0, 0);
        step(0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, "down wrap",     1, 5, 9);
        step(0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, "down 58",       0, 5, 8);
`else
        step(0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, "load 05",      0, 0, 5);
        step(0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, "dir ignored",  0, 0, 6);
        step(0, 1'b1, 4'd5, 4'd9, 1'b0, 1'b0, "load 59 dn",   0, 5, 9);
        step(0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, "up wrap dir1", 1, 0, 0);
`endif

        // Randomised run of the seconds instance against an integer model.
        v = 0;
        for (int i = 0; i < 400; i++) begin
            rn = (i == 0) ? 1'b0 : ($urandom_range(0, 31) != 0);
            le = ($urandom_range(0, 7) == 0);
            e  = 1'($urandom_range(0, 1));
            d  = 1'($urandom_range(0, 1));
            m  = 4'($urandom_range(0, 15));
            l  = 4'($urandom_range(0, 15));
`ifdef BCD_TIME_REGISTER_DOWN_EN
            dn = d;
`else
            dn = 1'b0;
`endif
            xo = (rn && e && !le && (dn ? (v == 0) : (v == 59))) ? 1 : 0;
            if (!rn)
                nv = 0;
            else if (le)
                nv = (m <= 9 && l <= 9 && (10 * int'(m) + int'(l)) <= 59) ? 10 * int'(m) + int'(l) : 0;
            else if (e)
                nv = dn ? ((v == 0) ? 59 : v - 1) : ((v == 59) ? 0 : v + 1);
            else
                nv = v;
            rst_n[0] = rn; load_en[0] = le; en[0] = e; dir[0] = d; lm[0] = m; ll[0] = l;
            #1;
            chk("rand ovf", int'(ovf[0]), xo);
            @(posedge clk); #1;
            v = nv;
            chk("rand msd", int'(dm[0]), v / 10);
            chk("rand lsd", int'(dl[0]), v % 10);
        end

        // Chained seconds -> minutes with en held for a full hour.
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        load_en[0] = 1'b0; en[0] = 1'b0; dir[0] = 1'b0;
        load_en[1] = 1'b0; dir[1] = 1'b0; lm[1] = 4'd0; ll[1] = 4'd0;
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        en[0] = 1'b1;
        ovc = 0;
        for (int i = 0; i < 3600; i++) begin
            #1;
            if (i < 60 && ovf[0]) ovc++;
            @(posedge clk); #1;
            if (i < 60) begin
                chk("chain sec msd", int'(dm[0]), ((i + 1) % 60) / 10);
                chk("chain sec lsd", int'(dl[0]), ((i + 1) % 60) % 10);
            end
            if (i == 59) begin
                chk("chain ovf count", ovc, 1);
                chk("chain min msd 60", int'(dm[1]), 0);
                chk("chain min lsd 60", int'(dl[1]), 1);
            end
        end
        chk("chain min msd 3600", int'(dm[1]), 0);
        chk("chain min lsd 3600", int'(dl[1]), 0);
        chk("chain sec 3600", 10 * int'(dm[0]) + int'(dl[0]), 0);
        en[0] = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
